food_position_gen: RTL and testbench

Parametrised food-placement generator for the snake playfield. On request it draws pseudo-random grid coordinates from a free-running LFSR, rejects out-of-range draws, and confirms each candidate against the snake-body occupancy checker through a query handshake. After a bounded number of random attempts it falls back to a deterministic raster scan, so any free cell is always found. It sits between the game-control FSM, which raises `req`, and the body/collision logic, which answers the occupancy queries.

---
 rtl/food_position_gen_pkg.sv | 28 ++
 rtl/food_position_gen_lfsr_galois.sv | 39 +++
 rtl/food_position_gen.sv | 193 +++++++++++++++++++
 tb/tb_food_position_gen.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/food_position_gen_pkg.sv
// Shared types and constants for the food placement generator and its LFSR.
package food_position_gen_pkg;

  localparam int GRID_W_DEF = 96;
  localparam int GRID_H_DEF = 48;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAW,
    ST_QUERY,
    ST_SCAN,
    ST_SCANQ,
    ST_DONE
  } state_t;

  // Right-shifting Galois masks for maximal-length sequences; unknown widths get the 16-bit mask.
  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      8:       return 32'h0000_00B8;
      16:      return 32'h0000_B400;
      20:      return 32'h0009_0000;
      24:      return 32'h00E1_0000;
      32:      return 32'h8020_0003;
      default: return 32'h0000_B400;
    endcase
  endfunction

endpackage

// File: rtl/food_position_gen_lfsr_galois.sv
// Free-running Galois LFSR with synchronous load; an all-zero seed or load value is forced to 1.
module lfsr_galois #(
  parameter int               WIDTH = 16,
  parameter logic [WIDTH-1:0] TAPS  = 'hB400,
  parameter logic [WIDTH-1:0] SEED  = 'hACE1
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] state
);

  localparam logic [WIDTH-1:0] SEED_NZ = (SEED == '0) ? WIDTH'(1) : SEED;

  logic [WIDTH-1:0] state_reg;
  logic [WIDTH-1:0] state_next;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH - 1; gi++) begin : g_shift
      assign state_next[gi] = state_reg[gi+1] ^ (TAPS[gi] & state_reg[0]);
    end
  endgenerate
  assign state_next[WIDTH-1] = TAPS[WIDTH-1] & state_reg[0];

  always_ff @(posedge clk) begin
    if (srst) begin
      state_reg <= SEED_NZ;
    end else if (load) begin
      state_reg <= (load_val == '0) ? WIDTH'(1) : load_val;
    end else begin
      state_reg <= state_next;
    end
  end

  assign state = state_reg;

endmodule

// File: rtl/food_position_gen.sv
// Food placement: random draws confirmed by occupancy queries, with a raster-scan fallback
// that guarantees a free cell is found (or reports a full grid).
module food_position_gen
  import food_position_gen_pkg::*;
#(
  parameter int          GRID_W    = GRID_W_DEF,
  parameter int          GRID_H    = GRID_H_DEF,
  parameter int          X_BITS    = 7,
  parameter int          Y_BITS    = 6,
  parameter int          LFSR_W    = 16,
  parameter int unsigned SEED      = 32'h0000_ACE1,
  parameter int          MAX_TRIES = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed_in,
  output logic [X_BITS-1:0] cand_x,
  output logic [Y_BITS-1:0] cand_y,
  output logic              cand_valid,
  input  logic              occ_ack,
  input  logic              occ_hit,
  output logic [X_BITS-1:0] x_out,
  output logic [Y_BITS-1:0] y_out,
  output logic              pos_valid,
  output logic              busy,
  output logic              fail
);

  localparam int NCELLS = GRID_W * GRID_H;
  localparam int TRY_W  = $clog2(MAX_TRIES + 1);
  localparam int SCAN_W = $clog2(NCELLS + 1);
  localparam logic [TRY_W-1:0]  TRY_LAST = TRY_W'(MAX_TRIES);
  localparam logic [SCAN_W-1:0] SCAN_ALL = SCAN_W'(NCELLS);
  localparam logic [X_BITS-1:0] X_LAST   = X_BITS'(GRID_W - 1);
  localparam logic [Y_BITS-1:0] Y_LAST   = Y_BITS'(GRID_H - 1);

  state_t state_reg, state_next;

  logic [LFSR_W-1:0] lfsr;
  logic [X_BITS-1:0] raw_x, cand_x_reg, x_out_reg, scan_x;
  logic [Y_BITS-1:0] raw_y, cand_y_reg, y_out_reg, scan_y;
  logic [TRY_W-1:0]  tries_reg, tries_inc;
  logic [SCAN_W-1:0] scan_cnt_reg;
  logic              fail_reg;
  logic              draw_ok, tries_full, scan_left;

  lfsr_galois #(
    .WIDTH (LFSR_W),
    .TAPS  (LFSR_W'(lfsr_taps(LFSR_W))),
    .SEED  (LFSR_W'(SEED))
  ) u_lfsr (
    .clk      (clk),
    .srst     (rst),
    .load     (seed_load),
    .load_val (seed_in),
    .state    (lfsr)
  );

  // Draw bits above the coordinate fields are never used.
  generate
    if (LFSR_W > X_BITS + Y_BITS) begin : g_spare
      logic lfsr_unused;
      assign lfsr_unused = ^lfsr[LFSR_W-1:X_BITS+Y_BITS];
    end
  endgenerate

  assign raw_x      = lfsr[X_BITS-1:0];
  assign raw_y      = lfsr[X_BITS+Y_BITS-1:X_BITS];
  assign draw_ok    = (int'(raw_x) < GRID_W) && (int'(raw_y) < GRID_H);
  assign tries_inc  = tries_reg + 1'b1;
  assign tries_full = (tries_inc == TRY_LAST);
  assign scan_left  = (scan_cnt_reg < SCAN_ALL);

  // Raster successor of the current candidate.
  always_comb begin
    scan_x = cand_x_reg + 1'b1;
    scan_y = cand_y_reg;
    if (cand_x_reg == X_LAST) begin
      scan_x = '0;
      scan_y = (cand_y_reg == Y_LAST) ? '0 : cand_y_reg + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (req) state_next = ST_DRAW;
      ST_DRAW: begin
        if (draw_ok)         state_next = ST_QUERY;
        else if (tries_full) state_next = ST_SCAN;
      end
      ST_QUERY: begin
        if (occ_ack) begin
          if (!occ_hit)        state_next = ST_DONE;
          else if (tries_full) state_next = ST_SCAN;
          else                 state_next = ST_DRAW;
        end
      end
      ST_SCAN:  state_next = ST_SCANQ;
      ST_SCANQ: begin
        if (occ_ack) begin
          if (!occ_hit)       state_next = ST_DONE;
          else if (scan_left) state_next = ST_SCAN;
          else                state_next = ST_IDLE;
        end
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cand_valid = (state_reg == ST_QUERY) || (state_reg == ST_SCANQ);
    busy       = (state_reg != ST_IDLE);
    pos_valid  = (state_reg == ST_DONE);
  end

  // Result is registered on the accepting ack so it is already visible while pos_valid is high.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_x_reg   <= '0;
      cand_y_reg   <= '0;
      x_out_reg    <= '0;
      y_out_reg    <= '0;
      tries_reg    <= '0;
      scan_cnt_reg <= '0;
      fail_reg     <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (req) begin
            fail_reg     <= 1'b0;
            tries_reg    <= '0;
            scan_cnt_reg <= '0;
            cand_x_reg   <= '0;
            cand_y_reg   <= '0;
          end
        end
        ST_DRAW: begin
          if (draw_ok) begin
            cand_x_reg <= raw_x;
            cand_y_reg <= raw_y;
          end else begin
            tries_reg <= tries_inc;
          end
        end
        ST_QUERY: begin
          if (occ_ack) begin
            if (!occ_hit) begin
              x_out_reg <= cand_x_reg;
              y_out_reg <= cand_y_reg;
            end else begin
              tries_reg <= tries_inc;
            end
          end
        end
        ST_SCAN: begin
          cand_x_reg   <= scan_x;
          cand_y_reg   <= scan_y;
          scan_cnt_reg <= scan_cnt_reg + 1'b1;
        end
        ST_SCANQ: begin
          if (occ_ack) begin
            if (!occ_hit) begin
              x_out_reg <= cand_x_reg;
              y_out_reg <= cand_y_reg;
            end else if (!scan_left) begin
              fail_reg <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign cand_x = cand_x_reg;
  assign cand_y = cand_y_reg;
  assign x_out  = x_out_reg;
  assign y_out  = y_out_reg;
  assign fail   = fail_reg;

endmodule

// File: tb/tb_food_position_gen.sv
// Scoreboard bench: a transaction-level search model predicts every query and result.
module tb_food_position_gen;

  localparam int GW = 96;
  localparam int GH = 48;
  localparam int MAXT = 32;
  localparam int NCELLS = GW * GH;
  localparam logic [15:0] SEED_DEF = 16'hACE1;

  logic        clk, rst, req, seed_load;
  logic [15:0] seed_in;
  logic [6:0]  cand_x, x_out;
  logic [5:0]  cand_y, y_out;
  logic        cand_valid, occ_ack, occ_hit, pos_valid, busy, fail;

  food_position_gen dut (
    .clk(clk), .rst(rst), .req(req), .seed_load(seed_load), .seed_in(seed_in),
    .cand_x(cand_x), .cand_y(cand_y), .cand_valid(cand_valid),
    .occ_ack(occ_ack), .occ_hit(occ_hit),
    .x_out(x_out), .y_out(y_out), .pos_valid(pos_valid), .busy(busy), .fail(fail)
  );

  typedef struct { int x; int y; int cyc; int lat; bit hit; } qexp_t;
  typedef struct { bit is_fail; int x; int y; int cyc; } rexp_t;

  qexp_t qq[$];
  rexp_t rq[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int nq = 0;
  int base_cyc = 0;
  logic [15:0] base_val = SEED_DEF;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s: event not expected (cycle %0d)", name, cyc);
  endtask

  // Reference model: LFSR rule, occupancy scenarios, and the search procedure.
  function automatic logic [15:0] lstep(input logic [15:0] s);
    return (s >> 1) ^ (s[0] ? 16'hB400 : 16'h0000);
  endfunction

  function automatic logic [15:0] lfsr_at(input int c);
    logic [15:0] s = base_val;
    for (int i = base_cyc; i < c; i++) s = lstep(s);
    return s;
  endfunction

  function automatic bit occupied(input int mode, input int x, input int y, input int q,
                                  input int ex, input int ey, input int nhit, input int salt);
    case (mode)
      0:       return 1'b0;
      1:       return q < nhit;
      2:       return !(x == ex && y == ey);
      3:       return 1'b1;
      default: return ((x * 31 + y * 17 + salt) % 5) != 0;
    endcase
  endfunction

  function automatic int lat_of(input int lat_base, input int lat_max, input int q);
    return (lat_max == 0) ? 0 : (lat_base + q) % (lat_max + 1);
  endfunction

  task automatic push_q(input int x, input int y, input int c, input int lat, input bit hit);
    qexp_t e;
    e.x = x; e.y = y; e.cyc = c; e.lat = lat; e.hit = hit;
    qq.push_back(e);
  endtask

  task automatic push_r(input bit f, input int x, input int y, input int c);
    rexp_t e;
    e.is_fail = f; e.x = x; e.y = y; e.cyc = c;
    rq.push_back(e);
  endtask

  // req driven in cycle c0; first DRAW is cycle c0+1.
  task automatic predict(input int c0, input int mode, input int lat_base, input int lat_max,
                         input int ex, input int ey, input int nhit, input int salt,
                         output int busy_low, output int nqe);
    logic [15:0] v;
    int t, tries, q, a, lat, cx, cy, cnt, x, y;
    bit hit;
    v = lfsr_at(c0 + 1);
    t = c0 + 1; tries = 0; q = 0; cx = 0; cy = 0;
    while (tries < MAXT) begin
      x = int'(v[6:0]);
      y = int'(v[12:7]);
      if (x < GW && y < GH) begin
        cx = x; cy = y;
        lat = lat_of(lat_base, lat_max, q);
        hit = occupied(mode, x, y, q, ex, ey, nhit, salt);
        push_q(x, y, t + 1, lat, hit);
        q++;
        a = t + 1 + lat;
        if (!hit) begin
          push_r(1'b0, x, y, a + 1);
          busy_low = a + 2; nqe = q;
          return;
        end
        tries++;
        for (int i = t; i < a + 1; i++) v = lstep(v);
        t = a + 1;
      end else begin
        tries++;
        v = lstep(v);
        t++;
      end
    end
    cnt = 0;
    forever begin
      if (cx == GW - 1) begin
        cx = 0;
        cy = (cy == GH - 1) ? 0 : cy + 1;
      end else begin
        cx++;
      end
      cnt++;
      lat = lat_of(lat_base, lat_max, q);
      hit = occupied(mode, cx, cy, q, ex, ey, nhit, salt);
      push_q(cx, cy, t + 1, lat, hit);
      q++;
      a = t + 1 + lat;
      if (!hit) begin
        push_r(1'b0, cx, cy, a + 1);
        busy_low = a + 2; nqe = q;
        return;
      end
      if (cnt >= NCELLS) begin
        push_r(1'b1, 0, 0, a + 1);
        busy_low = a + 1; nqe = q;
        return;
      end
      t = a + 1;
    end
  endtask

  // Occupancy responder: pops the predicted query, checks it, answers with its latency/hit.
  bit in_q = 0;
  int wait_left = 0;
  bit cur_hit = 0;
  logic [6:0] hx;
  logic [5:0] hy;

  initial begin
    qexp_t e;
    occ_ack = 1'b0;
    occ_hit = 1'b0;
    forever begin
      @(posedge clk); #1;
      occ_ack = 1'b0;
      occ_hit = 1'b0;
      if (rst) begin
        in_q = 0;
      end else if (cand_valid) begin
        if (!in_q) begin
          in_q = 1;
          nq++;
          hx = cand_x; hy = cand_y;
          if (qq.size() == 0) begin
            flag("query_unexpected");
            wait_left = 0; cur_hit = 0;
          end else begin
            e = qq.pop_front();
            check("query_x", cand_x, e.x);
            check("query_y", cand_y, e.y);
            check("query_cycle", cyc, e.cyc);
            wait_left = e.lat; cur_hit = e.hit;
          end
        end else if (cand_x !== hx || cand_y !== hy) begin
          flag("cand_not_held");
        end
        if (wait_left == 0) begin
          occ_ack = 1'b1;
          occ_hit = cur_hit;
          in_q = 0;
        end else begin
          wait_left--;
        end
      end else if ($urandom_range(7) == 0) begin
        occ_ack = 1'b1;
        occ_hit = 1'($urandom_range(1));
      end
    end
  end

  // Result monitor.
  logic fail_prev = 1'b0;
  initial begin
    rexp_t e;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        if (pos_valid) begin
          if (rq.size() == 0) flag("pos_valid_unexpected");
          else begin
            e = rq.pop_front();
            check("result_is_fail", 32'd0, 32'(e.is_fail));
            check("x_out", x_out, e.x);
            check("y_out", y_out, e.y);
            check("result_cycle", cyc, e.cyc);
          end
        end
        if (fail && !fail_prev) begin
          if (rq.size() == 0) flag("fail_unexpected");
          else begin
            e = rq.pop_front();
            check("result_is_fail", 32'd1, 32'(e.is_fail));
            check("fail_cycle", cyc, e.cyc);
          end
        end
      end
      fail_prev = fail;
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic load_seed(input logic [15:0] s);
    seed_in = s;
    seed_load = 1'b1;
    step(1);
    seed_load = 1'b0;
    base_cyc = cyc;
    base_val = (s == 16'h0) ? 16'h0001 : s;
  endtask

  task automatic run_req(input int mode, input int lat_base, input int lat_max, input int ex,
                         input int ey, input int nhit, input int salt, input bit dbl);
    int c0, bl, nq0, nqe;
    c0 = cyc;
    nq0 = nq;
    req = 1'b1;
    predict(c0, mode, lat_base, lat_max, ex, ey, nhit, salt, bl, nqe);
    step(1);
    req = 1'b0;
    check("busy_rise", busy, 1);
    check("fail_cleared", fail, 0);
    if (dbl) begin
      step(1);
      req = 1'b1;
      step(1);
      req = 1'b0;
    end
    while (cyc < bl) step(1);
    check("busy_fall", busy, 0);
    step(1);
    check("query_count", nq - nq0, nqe);
    check("queues_drained", qq.size() + rq.size(), 0);
    $display("txn mode=%0d lat_max=%0d queries=%0d x_out=%0d y_out=%0d fail=%0d",
             mode, lat_max, nq - nq0, x_out, y_out, fail);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int nq0;
    rst = 1'b1; req = 1'b0; seed_load = 1'b0; seed_in = 16'h0;
    step(3);
    rst = 1'b0;
    base_cyc = cyc;
    base_val = SEED_DEF;
    check("rst_x_out", x_out, 0);
    check("rst_y_out", y_out, 0);
    check("rst_cand_x", cand_x, 0);
    check("rst_cand_y", cand_y, 0);
    check("rst_cand_valid", cand_valid, 0);
    check("rst_pos_valid", pos_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_fail", fail, 0);

    // Empty grid, zero-latency answers.
    run_req(0, 0, 0, 0, 0, 0, 0, 1'b0);
    check("x_in_range", 32'(x_out < 7'd96), 1);
    check("y_in_range", 32'(y_out < 6'd48), 1);

    // Three rejections, then the fourth candidate is accepted.
    run_req(1, 1, 2, 0, 0, 3, 0, 1'b0);

    // Randomised requests.
    for (int i = 0; i < 20; i++) begin
      int m;
      m = (i % 3 == 0) ? 0 : ((i % 3 == 1) ? 1 : 4);
      if ($urandom_range(4) == 0) load_seed(16'($urandom));
      run_req(m, int'($urandom_range(7)), int'($urandom_range(3)), 0, 0,
              int'($urandom_range(5)), int'($urandom_range(1000)), 1'($urandom_range(1)));
      step(int'($urandom_range(3)));
    end

    // Only (5,2) free: random phase exhausts, scan finds it.
    nq0 = nq;
    run_req(2, 0, 1, 5, 2, 0, 0, 1'b0);
    check("scan_x_out", x_out, 5);
    check("scan_y_out", y_out, 2);
    check("scan_bound", 32'(nq - nq0 <= MAXT + NCELLS), 1);

    // Full grid: fail without pos_valid, then cleared by the next request.
    run_req(3, 0, 1, 0, 0, 0, 0, 1'b0);
    check("fail_set", fail, 1);
    run_req(0, 2, 3, 0, 0, 0, 0, 1'b0);

    // Repeatable sequences after reseeding, including the zero seed.
    for (int r = 0; r < 2; r++) begin
      load_seed(16'h1234);
      for (int k = 0; k < 3; k++) begin
        run_req(0, 0, 0, 0, 0, 0, 0, 1'b0);
        step(2);
      end
    end
    load_seed(16'h0000);
    run_req(0, 0, 0, 0, 0, 0, 0, 1'b0);
    load_seed(16'h0001);
    run_req(0, 0, 0, 0, 0, 0, 0, 1'b0);

    // Reset while a query is outstanding.
    begin
      int c0, bl, nqe, budget;
      c0 = cyc;
      req = 1'b1;
      predict(c0, 0, 1500, 2000, 0, 0, 0, 0, bl, nqe);
      step(1);
      req = 1'b0;
      budget = 0;
      while (!cand_valid && budget < 60) begin
        step(1);
        budget++;
      end
      check("query_started", cand_valid, 1);
      step(1);
      rst = 1'b1;
      step(1);
      check("mid_rst_cand_valid", cand_valid, 0);
      check("mid_rst_busy", busy, 0);
      check("mid_rst_pos_valid", pos_valid, 0);
      check("mid_rst_x_out", x_out, 0);
      check("mid_rst_y_out", y_out, 0);
      check("mid_rst_cand_x", cand_x, 0);
      check("mid_rst_fail", fail, 0);
      qq.delete();
      rq.delete();
      step(1);
      rst = 1'b0;
      base_cyc = cyc;
      base_val = SEED_DEF;
    end
    run_req(4, 3, 3, 0, 0, 0, 77, 1'b0);

    step(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
